taillight_seq_ctrl: RTL and testbench
=====================================

# taillight_seq_ctrl

Sequential taillight controller: the registered, parametrised successor to the combinational next-state decoder. It synchronises the driver switch inputs, holds the lighting mode in a state register and drives LAMPS lamps per side. Turn signals sweep outward one lamp per step; hazard flashes both sides; brake holds the non-signalling side lit. It sits between the board switch inputs and the LED pins of the DE10-Lite taillight design.

## Interface
- LAMPS, 3, lamps per side (≥2); bit 0 is the innermost lamp.
- STEP_CYCLES, 12_500_000, clock cycles per sequence step (0.25 s at 50 MHz); ≥2.
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- hzrd_in  input  1  hazard switch, asynchronous.
- brk_in  input  1  brake switch, asynchronous.
- sig_l_in  input  1  left turn switch, asynchronous.
- sig_r_in  input  1  right turn switch, asynchronous.
- lamp_l  output  LAMPS  left lamps, 1 = lit, registered.
- lamp_r  output  LAMPS  right lamps, 1 = lit, registered.
- state  output  3  current mode code, registered, for debug LEDs.

## Operation
- All four inputs pass through 2-flop synchronisers (reset to 0).
- Mode decode on synchronised inputs, priority order:
  - hazard → HZRD.
  - brk,l,r = 001 → SIG_R; 010 → SIG_L; 100 → BRK; 101 → BRK_SIG_R; 110 → BRK_SIG_L.
  - 111 → BRK (both turn switches cancel each other; brake wins).
  - 011 and 000 → IDLE.
- Step machine: prescaler counts 0..STEP_CYCLES-1; tick when it equals STEP_CYCLES-1, then it wraps to 0. Step counter runs 0..LAMPS.
- Lamp decode:
  - Signalling side shows the lowest `step` lamps lit. Step 0 is all off; step LAMPS is all on.
  - On each tick, step advances 1→2→…→LAMPS→0→1, giving a period of LAMPS+1 steps.
  - In HZRD, phase toggles on each tick; both sides are all-on when phase=1 and all-off when phase=0.
  - BRK: both sides all on. BRK_SIG_x: the non-signalling side is all on.
  - IDLE: all off.
- Mode change, i.e. decoded mode differs from `state`:
  - state, lamps, prescaler and step update on the same edge.
  - Prescaler → 0; step → 1, so the first lamp is lit immediately; hazard phase → 1.
  - The new pattern restarts from the beginning regardless of sweep position.
- Brake added or removed during a turn signal: this is a mode change, so the sweep restarts at step 1.
- Unused state codes are not reachable. If one occurs, next edge goes to IDLE with lamps all off.

## Timing
- Reset (async assert, sync release): state=IDLE, lamp_l=0, lamp_r=0, prescaler=0, step=0, phase=0, synchronisers=0.
- Input-to-output latency: a switch change stable before edge N appears in state/lamps after edge N+2 (2 sync edges plus 1 state edge).
- Step period is exactly STEP_CYCLES clocks. The first tick after a mode change occurs STEP_CYCLES cycles after the change edge.
- Inputs held steady cause no output glitches; every output is a flop.
- reset_n asserted mid-sweep clears everything within the same cycle, asynchronously. Sweep restarts from the first edge after release.

## Structure
- Shared include param.vh holds the 3-bit mode codes: IDLE, SIG_L, SIG_R, BRK, BRK_SIG_L, BRK_SIG_R, HZRD. This block and existing users share them.
- The existing combinational decoder, extended with the 111 → BRK rule, is instantiated as the next-state stage.
- Sub-module step_timer (parameter STEP_CYCLES) owns the prescaler and tick generation, with a synchronous clear input driven by mode change.

## Test plan
All scenarios use LAMPS=3 and STEP_CYCLES=4.
- Reset held, then released with inputs 0 → state=IDLE, lamps 000/000 for all following cycles.
- sig_l_in=1 → after 3 edges state=SIG_L, lamp_l=001. Then every 4 cycles 011, 111, 000, 001, …; lamp_r=000 throughout.
- brk_in=1 mid-sweep with lamp_l=011 → after 3 edges state=BRK_SIG_L, lamp_l=001, lamp_r=111, sweep continues 011, 111, 000.
- hzrd_in=1 with brk and sig_r active → state=HZRD, both 111 for 4 cycles, both 000 for 4 cycles, repeating. Releasing hzrd returns to BRK_SIG_R with lamp_r=001, lamp_l=111.
- brk, l, r all 1 → state=BRK, both 111, static. l=r=1 with no brake → IDLE, 000/000.
- reset_n pulsed low for less than one cycle mid-sweep → outputs 000/000 and state IDLE immediately. The sweep restarts at 001 three edges after release if sig_r_in is still held.

Source files
------------

// File: rtl/taillight_seq_ctrl_pkg.sv
// Shared mode codes and the combinational mode decoder for the taillight controller.
// Mode codes are the debug LED encoding, so their numeric values are fixed.
package taillight_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SIG_L     = 3'd1,
        SIG_R     = 3'd2,
        BRK       = 3'd3,
        BRK_SIG_L = 3'd4,
        BRK_SIG_R = 3'd5,
        HZRD      = 3'd6
    } mode_e;

    // Hazard overrides everything; both turn switches together cancel out.
    function automatic mode_e decode_mode(input logic hzrd, input logic brk,
                                          input logic sig_l, input logic sig_r);
        mode_e m;
        m = IDLE;
        if (hzrd) begin
            m = HZRD;
        end else begin
            case ({brk, sig_l, sig_r})
                3'b001:  m = SIG_R;
                3'b010:  m = SIG_L;
                3'b100:  m = BRK;
                3'b101:  m = BRK_SIG_R;
                3'b110:  m = BRK_SIG_L;
                3'b111:  m = BRK;
                default: m = IDLE;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/taillight_seq_ctrl_step_timer.sv
// Step prescaler: pulses tick once every STEP_CYCLES clocks; clear restarts the count.
module step_timer #(
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(STEP_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/taillight_seq_ctrl.sv
// Registered taillight controller: synchronised switches, mode register, outward sweep,
// hazard flash and brake hold, with every output driven straight from a flop.
module taillight_seq_ctrl
    import taillight_seq_ctrl_pkg::*;
#(
    parameter int LAMPS       = 3,
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hzrd_in,
    input  logic             brk_in,
    input  logic             sig_l_in,
    input  logic             sig_r_in,
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r,
    output logic [2:0]       state
);

    localparam int SW = $clog2(LAMPS + 1);

    logic [3:0]       sync_1, sync_2;
    mode_e            state_q, state_d, mode_next;
    logic [SW-1:0]    step_q, step_d;
    logic             phase_q, phase_d;
    logic [LAMPS-1:0] lamp_l_d, lamp_r_d, sweep;
    logic             bad_state, change, tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {hzrd_in, brk_in, sig_l_in, sig_r_in};
            sync_2 <= sync_1;
        end
    end

    assign mode_next = decode_mode(sync_2[3], sync_2[2], sync_2[1], sync_2[0]);
    assign bad_state = (state_q == 3'b111);
    assign change    = bad_state || (mode_next != state_q);

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (change),
        .tick   (tick)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        phase_d  = phase_q;
        sweep    = '0;
        lamp_l_d = '0;
        lamp_r_d = '0;

        if (bad_state) begin
            state_d = IDLE;
            step_d  = '0;
            phase_d = 1'b0;
        end else if (change) begin
            state_d = mode_next;
            step_d  = SW'(1);
            phase_d = 1'b1;
        end else if (tick) begin
            step_d  = (step_q == SW'(LAMPS)) ? '0 : step_q + SW'(1);
            phase_d = ~phase_q;
        end

        for (int i = 0; i < LAMPS; i++) begin
            sweep[i] = (i < int'(step_d));
        end

        // Lamps follow the next state so pattern and mode change on the same edge.
        case (state_d)
            SIG_L:     lamp_l_d = sweep;
            SIG_R:     lamp_r_d = sweep;
            BRK: begin
                lamp_l_d = '1;
                lamp_r_d = '1;
            end
            BRK_SIG_L: begin
                lamp_l_d = sweep;
                lamp_r_d = '1;
            end
            BRK_SIG_R: begin
                lamp_l_d = '1;
                lamp_r_d = sweep;
            end
            HZRD: begin
                lamp_l_d = {LAMPS{phase_d}};
                lamp_r_d = {LAMPS{phase_d}};
            end
            default: begin
                lamp_l_d = '0;
                lamp_r_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            phase_q <= 1'b0;
            lamp_l  <= '0;
            lamp_r  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            lamp_l  <= lamp_l_d;
            lamp_r  <= lamp_r_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_taillight_seq_ctrl.sv
// Directed bench for taillight_seq_ctrl with LAMPS=3, STEP_CYCLES=4; expected values are hand-derived.
module tb_taillight_seq_ctrl;

    localparam int LAMPS       = 3;
    localparam int STEP_CYCLES = 4;

    localparam int M_IDLE      = 0;
    localparam int M_SIG_L     = 1;
    localparam int M_SIG_R     = 2;
    localparam int M_BRK       = 3;
    localparam int M_BRK_SIG_L = 4;
    localparam int M_BRK_SIG_R = 5;
    localparam int M_HZRD      = 6;

    logic             clk;
    logic             reset_n;
    logic             hzrd_in, brk_in, sig_l_in, sig_r_in;
    logic [LAMPS-1:0] lamp_l, lamp_r;
    logic [2:0]       state;

    int n_cmp;
    int n_err;

    // Sweep after 0,4,8,12 cycles from a mode change.
    int sweep_seq [4] = '{1, 3, 7, 0};

    taillight_seq_ctrl #(
        .LAMPS      (LAMPS),
        .STEP_CYCLES(STEP_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hzrd_in (hzrd_in),
        .brk_in  (brk_in),
        .sig_l_in(sig_l_in),
        .sig_r_in(sig_r_in),
        .lamp_l  (lamp_l),
        .lamp_r  (lamp_r),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int st, input int l, input int r);
        check({tag, ".state"},  int'(state),  st);
        check({tag, ".lamp_l"}, int'(lamp_l), l);
        check({tag, ".lamp_r"}, int'(lamp_r), r);
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        hzrd_in  = 1'b0;
        brk_in   = 1'b0;
        sig_l_in = 1'b0;
        sig_r_in = 1'b0;

        cyc(3);
        check_out("reset_held", M_IDLE, 0, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            check_out("idle_after_reset", M_IDLE, 0, 0);
        end

        // Left turn: two sync edges, then the mode edge.
        sig_l_in = 1'b1;
        cyc(2);
        check("sig_l_latency.state", int'(state), M_IDLE);
        cyc(1);
        check_out("sig_l_start", M_SIG_L, 1, 0);
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            check_out("sig_l_sweep", M_SIG_L, sweep_seq[(k / 4) % 4], 0);
        end

        // lamp_l is 011 here; brake restarts the sweep.
        brk_in = 1'b1;
        cyc(2);
        check_out("brk_latency", M_SIG_L, 3, 0);
        cyc(1);
        check_out("brk_sig_l_start", M_BRK_SIG_L, 1, 7);
        for (int k = 1; k < 12; k++) begin
            cyc(1);
            check_out("brk_sig_l_sweep", M_BRK_SIG_L, sweep_seq[k / 4], 7);
        end

        sig_l_in = 1'b0;
        sig_r_in = 1'b1;
        cyc(3);
        check_out("brk_sig_r_start", M_BRK_SIG_R, 7, 1);

        hzrd_in = 1'b1;
        cyc(3);
        check_out("hzrd_start", M_HZRD, 7, 7);
        for (int k = 1; k < 16; k++) begin
            cyc(1);
            check_out("hzrd_flash", M_HZRD, ((k / 4) % 2 == 0) ? 7 : 0,
                      ((k / 4) % 2 == 0) ? 7 : 0);
        end

        hzrd_in = 1'b0;
        cyc(3);
        check_out("hzrd_release", M_BRK_SIG_R, 7, 1);

        sig_l_in = 1'b1;
        cyc(3);
        check_out("brk_lr_start", M_BRK, 7, 7);
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            check_out("brk_lr_static", M_BRK, 7, 7);
        end

        brk_in = 1'b0;
        cyc(3);
        check_out("lr_cancel", M_IDLE, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check_out("lr_cancel_static", M_IDLE, 0, 0);
        end

        sig_l_in = 1'b0;
        cyc(3);
        check_out("sig_r_start", M_SIG_R, 0, 1);
        cyc(5);
        check_out("sig_r_mid", M_SIG_R, 0, 3);

        // Sub-cycle reset pulse between edges.
        reset_n = 1'b0;
        #1;
        check_out("async_reset", M_IDLE, 0, 0);
        #2;
        reset_n = 1'b1;
        cyc(2);
        check_out("post_reset_sync", M_IDLE, 0, 0);
        cyc(1);
        check_out("post_reset_restart", M_SIG_R, 0, 1);
        cyc(4);
        check_out("post_reset_step2", M_SIG_R, 0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
